// File: rtl/ldm_stm_seq_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ldm_stm_seq_pkg                                                       |
// | Shared state encoding and constants for the LDM/STM sequencer.        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package ldm_stm_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_WB   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int         WORD_BYTES = 4;
    localparam logic [3:0] PC_IDX     = 4'd15;

endpackage
`default_nettype wire

// File: rtl/ldm_stm_seq_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ldm_stm_seq_if                                                        |
// | Command, regfile and data-memory signals of the LDM/STM sequencer.    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface ldm_stm_seq_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              start;
    logic              is_load;
    logic              pre;
    logic              up;
    logic              wback;
    logic [3:0]        rn;
    logic [15:0]       reglist;
    logic [ADDR_W-1:0] base;

    logic [3:0]        ra;
    logic [DATA_W-1:0] rd;
    logic              regWrite;
    logic [3:0]        wa3;
    logic [DATA_W-1:0] wd3;
    logic              pc_we;
    logic [DATA_W-1:0] pc_wd;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              busy;
    logic              done;

    modport master (
        input  start, is_load, pre, up, wback, rn, reglist, base,
        input  rd, mem_rdata, mem_ready,
        output ra, regWrite, wa3, wd3, pc_we, pc_wd,
        output mem_req, mem_we, mem_addr, mem_wdata, busy, done
    );

    modport slave (
        output start, is_load, pre, up, wback, rn, reglist, base,
        output rd, mem_rdata, mem_ready,
        input  ra, regWrite, wa3, wd3, pc_we, pc_wd,
        input  mem_req, mem_we, mem_addr, mem_wdata, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/ldm_stm_seq_reglist_pick.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ldm_stm_seq_reglist_pick                                              |
// | Lowest set index and popcount of a 16-bit register list.              |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module ldm_stm_seq_reglist_pick (
    input  logic [15:0] i_list,
    output logic [3:0]  o_idx,
    output logic [4:0]  o_count
);
    always_comb begin
        o_idx   = 4'd0;
        o_count = 5'd0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = 15; i >= 0; i--) begin
            if (i_list[i]) begin
                o_idx = 4'(i);
            end
            o_count = o_count + 5'(i_list[i]);
        end
    end
endmodule
`default_nettype wire

// File: rtl/ldm_stm_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ldm_stm_seq                                                           |
// | Load/store-multiple sequencer: walks a register list over memory.     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module ldm_stm_seq
    import ldm_stm_seq_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    ldm_stm_seq_if.master     bus
);
    state_t            state_q,   state_d;
    logic [15:0]       list_q,    list_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [ADDR_W-1:0] final_q,   final_d;
    logic              is_load_q, is_load_d;
    logic              do_wb_q,   do_wb_d;
    logic [3:0]        rn_q,      rn_d;

    logic [15:0]       w_pick_list;
    logic [3:0]        w_pick_idx;
    logic [4:0]        w_pick_cnt;
    logic [ADDR_W-1:0] w_span;
    logic [ADDR_W-1:0] w_word;
    logic              w_last;

    // One encoder serves both the start popcount (IDLE) and the walk (XFER).
    assign w_pick_list = (state_q == S_IDLE) ? bus.reglist : list_q;

    ldm_stm_seq_reglist_pick u_pick (
        .i_list  (w_pick_list),
        .o_idx   (w_pick_idx),
        .o_count (w_pick_cnt)
    );

    assign w_word = ADDR_W'(WORD_BYTES);
    assign w_span = ADDR_W'(w_pick_cnt) << 2;
    assign w_last = (w_pick_cnt == 5'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            list_q    <= '0;
            addr_q    <= '0;
            final_q   <= '0;
            is_load_q <= 1'b0;
            do_wb_q   <= 1'b0;
            rn_q      <= '0;
        end else begin
            state_q   <= state_d;
            list_q    <= list_d;
            addr_q    <= addr_d;
            final_q   <= final_d;
            is_load_q <= is_load_d;
            do_wb_q   <= do_wb_d;
            rn_q      <= rn_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        list_d    = list_q;
        addr_d    = addr_q;
        final_d   = final_q;
        is_load_d = is_load_q;
        do_wb_d   = do_wb_q;
        rn_d      = rn_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    list_d    = bus.reglist;
                    is_load_d = bus.is_load;
                    rn_d      = bus.rn;
                    // A loaded base register takes priority over writeback.
                    do_wb_d   = bus.wback && !(bus.is_load && bus.reglist[bus.rn]);
                    final_d   = bus.up ? (bus.base + w_span) : (bus.base - w_span);
                    case ({bus.pre, bus.up})
                        2'b01:   addr_d = bus.base;
                        2'b11:   addr_d = bus.base + w_word;
                        2'b00:   addr_d = bus.base - w_span + w_word;
                        default: addr_d = bus.base - w_span;
                    endcase
                    state_d = (w_pick_cnt == 5'd0) ? S_DONE : S_XFER;
                end
            end
            S_XFER: begin
                if (bus.mem_ready) begin
                    list_d[w_pick_idx] = 1'b0;
                    addr_d             = addr_q + w_word;
                    if (w_last) begin
                        state_d = do_wb_q ? S_WB : S_DONE;
                    end
                end
            end
            S_WB:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are held quiet while reset is asserted so an aborted
    // transfer cannot issue one last register or PC write.
    always_comb begin
        bus.ra        = '0;
        bus.regWrite  = 1'b0;
        bus.wa3       = '0;
        bus.wd3       = '0;
        bus.pc_we     = 1'b0;
        bus.pc_wd     = '0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        if (!reset) begin
            case (state_q)
                S_XFER: begin
                    bus.busy      = 1'b1;
                    bus.mem_req   = 1'b1;
                    bus.mem_we    = !is_load_q;
                    bus.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                    bus.ra        = w_pick_idx;
                    bus.mem_wdata = bus.rd;
                    if (is_load_q && bus.mem_ready) begin
                        if (w_pick_idx == PC_IDX) begin
                            bus.pc_we = 1'b1;
                            bus.pc_wd = bus.mem_rdata;
                        end else begin
                            bus.regWrite = 1'b1;
                            bus.wa3      = w_pick_idx;
                            bus.wd3      = bus.mem_rdata;
                        end
                    end
                end
                S_WB: begin
                    bus.busy     = 1'b1;
                    bus.regWrite = 1'b1;
                    bus.wa3      = rn_q;
                    bus.wd3      = DATA_W'(final_q);
                end
                S_DONE: begin
                    bus.busy = 1'b1;
                    bus.done = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ldm_stm_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_ldm_stm_seq                                                        |
// | Directed bench with a transfer-list model compared every cycle.       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_ldm_stm_seq;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ldm_stm_seq_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    ldm_stm_seq #(.ADDR_W(32), .DATA_W(32)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    function automatic logic [31:0] rd_fn(input logic [3:0] r);
        return 32'hD0D0_0000 + 32'(r);
    endfunction

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign bus_if.rd        = rd_fn(bus_if.ra);
    assign bus_if.mem_rdata = mem_fn(bus_if.mem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an operation is a list of (register, address) transfers,
    // then an optional base writeback, then a done cycle.
    typedef struct {
        logic [3:0]  r;
        logic [31:0] a;
    } xfer_t;

    xfer_t       m_q[$];
    logic        m_wb_pend   = 1'b0;
    logic        m_done_pend = 1'b0;
    logic [31:0] m_wb_val    = '0;
    logic [3:0]  m_rn        = '0;
    logic        m_load      = 1'b0;

    always @(negedge clk) begin
        logic [3:0]  e_ra, e_wa3;
        logic [31:0] e_wd3, e_pcwd, e_addr, e_wdata, lo, n4;
        logic        e_rw, e_pcwe, e_req, e_we, e_busy, e_done;
        int          n, k;
        if (reset) begin
            m_q.delete();
            m_wb_pend   = 1'b0;
            m_done_pend = 1'b0;
        end else begin
            e_ra = '0; e_wa3 = '0; e_wd3 = '0; e_pcwd = '0; e_addr = '0; e_wdata = '0;
            e_rw = 1'b0; e_pcwe = 1'b0; e_req = 1'b0; e_we = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            if (m_q.size() > 0) begin
                e_busy  = 1'b1;
                e_req   = 1'b1;
                e_we    = !m_load;
                e_addr  = m_q[0].a & 32'hFFFF_FFFC;
                e_ra    = m_q[0].r;
                e_wdata = rd_fn(m_q[0].r);
                if (m_load && bus_if.mem_ready) begin
                    if (m_q[0].r == 4'd15) begin
                        e_pcwe = 1'b1;
                        e_pcwd = mem_fn(e_addr);
                    end else begin
                        e_rw  = 1'b1;
                        e_wa3 = m_q[0].r;
                        e_wd3 = mem_fn(e_addr);
                    end
                end
            end else if (m_wb_pend) begin
                e_busy = 1'b1;
                e_rw   = 1'b1;
                e_wa3  = m_rn;
                e_wd3  = m_wb_val;
            end else if (m_done_pend) begin
                e_busy = 1'b1;
                e_done = 1'b1;
            end
            chk("m_busy",      32'(bus_if.busy),      32'(e_busy));
            chk("m_done",      32'(bus_if.done),      32'(e_done));
            chk("m_mem_req",   32'(bus_if.mem_req),   32'(e_req));
            chk("m_mem_we",    32'(bus_if.mem_we),    32'(e_we));
            chk("m_mem_addr",  bus_if.mem_addr,       e_addr);
            chk("m_mem_wdata", bus_if.mem_wdata,      e_wdata);
            chk("m_ra",        32'(bus_if.ra),        32'(e_ra));
            chk("m_regWrite",  32'(bus_if.regWrite),  32'(e_rw));
            chk("m_wa3",       32'(bus_if.wa3),       32'(e_wa3));
            chk("m_wd3",       bus_if.wd3,            e_wd3);
            chk("m_pc_we",     32'(bus_if.pc_we),     32'(e_pcwe));
            chk("m_pc_wd",     bus_if.pc_wd,          e_pcwd);

            if (m_q.size() > 0) begin
                if (bus_if.mem_ready) void'(m_q.pop_front());
            end else if (m_wb_pend) begin
                m_wb_pend = 1'b0;
            end else if (m_done_pend) begin
                m_done_pend = 1'b0;
            end else if (bus_if.start) begin
                n  = $countones(bus_if.reglist);
                n4 = 32'(n) * 32'd4;
                if (bus_if.up) lo = bus_if.base + (bus_if.pre ? 32'd4 : 32'd0);
                else           lo = bus_if.base - n4 + (bus_if.pre ? 32'd0 : 32'd4);
                k = 0;
                for (int i = 0; i < 16; i++) begin
                    if (bus_if.reglist[i]) begin
                        m_q.push_back('{r: 4'(i), a: lo + 32'(k) * 32'd4});
                        k++;
                    end
                end
                m_load      = bus_if.is_load;
                m_rn        = bus_if.rn;
                m_wb_val    = bus_if.up ? bus_if.base + n4 : bus_if.base - n4;
                m_wb_pend   = (n > 0) && bus_if.wback && !(bus_if.is_load && bus_if.reglist[bus_if.rn]);
                m_done_pend = 1'b1;
            end
        end
    end

    task automatic start_cmd(input logic ld, input logic p, input logic u, input logic w,
                             input logic [3:0] rn, input logic [15:0] list, input logic [31:0] base);
        @(posedge clk); #1;
        bus_if.is_load = ld; bus_if.pre = p; bus_if.up = u; bus_if.wback = w;
        bus_if.rn = rn; bus_if.reglist = list; bus_if.base = base;
        bus_if.start = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        logic seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = bus_if.done;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.start = 1'b0; bus_if.is_load = 1'b0; bus_if.pre = 1'b0; bus_if.up = 1'b0;
        bus_if.wback = 1'b0; bus_if.rn = '0; bus_if.reglist = '0; bus_if.base = '0;
        bus_if.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(bus_if.busy), 32'd0);
        chk("rst_addr", bus_if.mem_addr, 32'd0);

        // STM IA R1-R3 from 0x100, writeback 0x10C into R4
        start_cmd(1'b0, 1'b0, 1'b1, 1'b1, 4'd4, 16'h000E, 32'h100);
        @(negedge clk); chk("ia_a1", bus_if.mem_addr, 32'h100); chk("ia_r1", 32'(bus_if.ra), 32'd1);
        chk("ia_d1", bus_if.mem_wdata, 32'hD0D0_0001);
        @(negedge clk); chk("ia_a2", bus_if.mem_addr, 32'h104);
        @(negedge clk); chk("ia_a3", bus_if.mem_addr, 32'h108); chk("ia_r3", 32'(bus_if.ra), 32'd3);
        @(negedge clk); chk("ia_wb_wa3", 32'(bus_if.wa3), 32'd4); chk("ia_wb_wd3", bus_if.wd3, 32'h10C);
        @(negedge clk); chk("ia_done5", 32'(bus_if.done), 32'd1);

        // LDM DB R0,R15 below 0x200
        start_cmd(1'b1, 1'b1, 1'b0, 1'b0, 4'd9, 16'h8001, 32'h200);
        @(negedge clk); chk("db_a0", bus_if.mem_addr, 32'h1F8); chk("db_rw0", 32'(bus_if.regWrite), 32'd1);
        chk("db_wd0", bus_if.wd3, 32'h5A5A_01F8);
        @(negedge clk); chk("db_a15", bus_if.mem_addr, 32'h1FC); chk("db_rw15", 32'(bus_if.regWrite), 32'd0);
        chk("db_pcwe", 32'(bus_if.pc_we), 32'd1); chk("db_pcwd", bus_if.pc_wd, 32'h5A5A_01FC);
        @(negedge clk); chk("db_done", 32'(bus_if.done), 32'd1);

        // LDM IB with Rn in list: loaded value wins, no writeback
        start_cmd(1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 16'h0004, 32'h300);
        @(negedge clk); chk("ib_a", bus_if.mem_addr, 32'h304); chk("ib_wa3", 32'(bus_if.wa3), 32'd2);
        chk("ib_wd3", bus_if.wd3, 32'h5A5A_0304);
        @(negedge clk); chk("ib_done", 32'(bus_if.done), 32'd1); chk("ib_nowb", 32'(bus_if.regWrite), 32'd0);

        // Empty list
        start_cmd(1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 16'h0000, 32'h80);
        @(negedge clk); chk("e_done", 32'(bus_if.done), 32'd1); chk("e_busy", 32'(bus_if.busy), 32'd1);
        chk("e_req", 32'(bus_if.mem_req), 32'd0);
        @(negedge clk); chk("e_busy2", 32'(bus_if.busy), 32'd0);

        // STM with wait states and an ignored start while busy
        start_cmd(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'h00F0, 32'h400);
        @(negedge clk); chk("st_a0", bus_if.mem_addr, 32'h400);
        @(posedge clk); #1;
        bus_if.mem_ready = 1'b0; bus_if.start = 1'b1; bus_if.is_load = 1'b1; bus_if.reglist = 16'hFFFF;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("st_addr", bus_if.mem_addr, 32'h404);
            chk("st_ra", 32'(bus_if.ra), 32'd5);
            chk("st_wdata", bus_if.mem_wdata, 32'hD0D0_0005);
            @(posedge clk); #1;
            bus_if.start = 1'b0;
            if (s == 2) bus_if.mem_ready = 1'b1;
        end
        wait_done("st_done");

        // Address wrap: 0xFFFF_FFFC + 4 = 0
        start_cmd(1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 16'h0003, 32'hFFFF_FFFC);
        @(negedge clk); chk("wr_a0", bus_if.mem_addr, 32'hFFFF_FFFC);
        @(negedge clk); chk("wr_a1", bus_if.mem_addr, 32'h0);
        @(negedge clk); chk("wr_wb", bus_if.wd3, 32'h4);
        wait_done("wr_done");

        // LDM DA, writeback of the decremented base
        start_cmd(1'b1, 1'b0, 1'b0, 1'b1, 4'd8, 16'h0007, 32'h10);
        @(negedge clk); chk("da_a0", bus_if.mem_addr, 32'h8);
        wait_done("da_done");

        // Reset during the second transfer of a 4-register LDM
        start_cmd(1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 16'h00F0, 32'h600);
        @(negedge clk);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            chk("ab_rw", 32'(bus_if.regWrite), 32'd0);
            chk("ab_req", 32'(bus_if.mem_req), 32'd0);
            chk("ab_busy", 32'(bus_if.busy), 32'd0);
        end

        // Normal operation after the abort
        start_cmd(1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 16'h0101, 32'h500);
        @(negedge clk); chk("rs_a0", bus_if.mem_addr, 32'h504); chk("rs_ra", 32'(bus_if.ra), 32'd0);
        wait_done("rs_done");
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
